four_input_rr_arbiter: RTL

- Round-robin arbiter that shares one downstream resource between four requesters (a, b, c, d → req[0..3]).
- Combinational any_req is the 4-input OR of the requests; it feeds the scheduler's wake-up and is exported.
- Grants are registered, one-hot, non-preemptive, bounded by a hold timeout, with a fixed idle gap between grants.

---
 rtl/four_input_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/four_input_rr_arbiter.sv
// Four-requester round-robin arbiter: registered one-hot grants, non-preemptive,
// bounded by a hold timeout, with one idle cycle between consecutive grants.
module four_input_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       any_req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   pick_c;
    logic              owner_leaves_c;
    logic              hold_limit_c;

    // First set request bit at or after the priority pointer, wrapping mod 4.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            hit;
        pick = p;
        hit  = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = p + ID_W'(i);
            if (!hit && r[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req        = |req;
    assign pick_c         = rr_pick(req, ptr_q);
    assign owner_leaves_c = done || !req[gnt_id_q];
    assign hold_limit_c   = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (any_req) begin
                    gnt_d       = N_REQ'(1) << pick_c;
                    gnt_id_d    = pick_c;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A voluntary release takes precedence over the hold limit.
                if (owner_leaves_c || hold_limit_c) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + ID_W'(1);
                    state_d     = ST_IDLE;
                    timeout_d   = !owner_leaves_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
